// File: rtl/rr_mux8_arbiter.sv
// Round-robin arbiter and sequencer for a shared 8-to-1 mux: one grant at a time,
// burst-limited, with a one-cycle idle bubble between consecutive grants.
module rr_mux8_arbiter #(
  parameter int DATA_W    = 8,
  parameter int MAX_BURST = 4
) (
  input  logic                clk,
  input  logic                rst,
  input  logic [7:0]          req,
  input  logic [8*DATA_W-1:0] din,
  input  logic                out_ready,
  output logic                out_valid,
  output logic [DATA_W-1:0]   out_data,
  output logic [2:0]          sel,
  output logic [7:0]          gnt,
  output logic                busy
);

  typedef enum logic {
    IDLE  = 1'b0,
    GRANT = 1'b1
  } state_t;

  localparam logic [3:0] LAST_BEAT = 4'(MAX_BURST - 1);

  state_t     state, state_nxt;
  logic [2:0] ptr, ptr_nxt;
  logic [2:0] sel_nxt;
  logic [7:0] gnt_nxt;
  logic       busy_nxt;
  logic [3:0] cnt, cnt_nxt;

  logic [2:0] winner;
  logic [2:0] idx;
  logic       found;
  logic       xfer;
  logic       release_now;

  // Rotating priority search starting at ptr; the first requester hit wins.
  always_comb begin
    winner = ptr;
    idx    = ptr;
    found  = 1'b0;
    for (int i = 0; i < 8; i++) begin
      idx = ptr + 3'(i);
      if (!found && req[idx]) begin
        winner = idx;
        found  = 1'b1;
      end
    end
  end

  assign out_valid   = (state == GRANT) && req[sel];
  assign out_data    = din[32'(sel)*DATA_W +: DATA_W];
  assign xfer        = out_valid && out_ready;
  // A withdrawal and a final beat in the same cycle collapse into one release.
  assign release_now = !req[sel] || (xfer && (cnt == LAST_BEAT));

  // NOTE: every output of this block gets a default first, so no path can leave
  // one unassigned and infer a latch.
  always_comb begin
    state_nxt = state;
    ptr_nxt   = ptr;
    sel_nxt   = sel;
    gnt_nxt   = gnt;
    busy_nxt  = busy;
    cnt_nxt   = cnt;
    case (state)
      IDLE: begin
        if (|req) begin
          state_nxt = GRANT;
          sel_nxt   = winner;
          gnt_nxt   = 8'b1 << winner;
          busy_nxt  = 1'b1;
          cnt_nxt   = 4'd0;
        end
      end
      GRANT: begin
        if (release_now) begin
          state_nxt = IDLE;
          gnt_nxt   = 8'h00;
          busy_nxt  = 1'b0;
          cnt_nxt   = 4'd0;
          ptr_nxt   = sel + 3'd1;
        end else if (xfer) begin
          cnt_nxt = cnt + 4'd1;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  // NOTE: non-blocking assignments here so every register samples the pre-edge
  // values computed above, independent of statement order.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
      ptr   <= 3'd0;
      sel   <= 3'd0;
      gnt   <= 8'h00;
      busy  <= 1'b0;
      cnt   <= 4'd0;
    end else begin
      state <= state_nxt;
      ptr   <= ptr_nxt;
      sel   <= sel_nxt;
      gnt   <= gnt_nxt;
      busy  <= busy_nxt;
      cnt   <= cnt_nxt;
    end
  end

endmodule

// File: tb/tb_rr_mux8_arbiter.sv
// Directed bench for rr_mux8_arbiter: reset, single and full-load rotation,
// pointer wrap, sink stall, requester withdrawal and mid-burst reset.
module tb_rr_mux8_arbiter;

  localparam int DATA_W = 8;

  logic                clk = 1'b0;
  logic                rst;
  logic [7:0]          req;
  logic [8*DATA_W-1:0] din;
  logic                out_ready;
  logic                out_valid;
  logic [DATA_W-1:0]   out_data;
  logic [2:0]          sel;
  logic [7:0]          gnt;
  logic                busy;

  int checks = 0;
  int errors = 0;

  rr_mux8_arbiter #(.DATA_W(DATA_W), .MAX_BURST(4)) dut (
    .clk       (clk),
    .rst       (rst),
    .req       (req),
    .din       (din),
    .out_ready (out_ready),
    .out_valid (out_valid),
    .out_data  (out_data),
    .sel       (sel),
    .gnt       (gnt),
    .busy      (busy)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    checks++;
    assert (observed === expected)
    else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, observed, expected);
    end
  endtask

  // Advance one clock and settle just after the edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [7:0] lane(input int k);
    return (k == 0) ? 8'hA5 : 8'(k * 8'h11);
  endfunction

  initial begin
    rst       = 1'b1;
    req       = 8'h00;
    out_ready = 1'b0;
    for (int k = 0; k < 8; k++) din[k*DATA_W +: DATA_W] = lane(k);

    // Reset state
    #3;
    check("rst_gnt", 32'(gnt), 32'h00);
    check("rst_busy", 32'(busy), 32'h0);
    check("rst_sel", 32'(sel), 32'h0);
    check("rst_valid", 32'(out_valid), 32'h0);
    check("rst_data", 32'(out_data), 32'hA5);
    tick();
    rst = 1'b0;

    // 1: no requests for 5 cycles
    for (int c = 0; c < 5; c++) begin
      tick();
      check("idle_gnt", 32'(gnt), 32'h00);
      check("idle_busy", 32'(busy), 32'h0);
      check("idle_sel", 32'(sel), 32'h0);
      check("idle_valid", 32'(out_valid), 32'h0);
    end

    // 2: single requester 0, four beats, bubble, re-grant
    req = 8'h01;
    out_ready = 1'b1;
    tick();
    check("t2_data", 32'(out_data), 32'hA5);
    for (int b = 0; b < 4; b++) begin
      check("t2_gnt", 32'(gnt), 32'h01);
      check("t2_valid", 32'(out_valid), 32'h1);
      tick();
    end
    check("t2_rel_gnt", 32'(gnt), 32'h00);
    check("t2_rel_busy", 32'(busy), 32'h0);
    check("t2_rel_sel", 32'(sel), 32'h0);
    check("t2_rel_valid", 32'(out_valid), 32'h0);
    tick();
    check("t2_regrant", 32'(gnt), 32'h01);

    // 3: all requesting; order 0..7 then wrap to 0, four beats each
    req = 8'hFF;
    for (int g = 0; g < 9; g++) begin
      for (int b = 0; b < 4; b++) begin
        check("t3_sel", 32'(sel), 32'(g % 8));
        check("t3_gnt", 32'(gnt), 32'(8'b1 << (g % 8)));
        check("t3_data", 32'(out_data), 32'(lane(g % 8)));
        check("t3_valid", 32'(out_valid), 32'h1);
        tick();
      end
      check("t3_bubble", 32'(busy), 32'h0);
      if (g < 8) tick();
    end

    // 4: ptr=1 now; grant 2 to move ptr to 3, then 8'h84 gives 7 then 2
    req = 8'h04;
    tick();
    check("t4_pre_sel", 32'(sel), 32'h2);
    for (int b = 0; b < 4; b++) tick();
    check("t4_pre_rel", 32'(busy), 32'h0);
    req = 8'h84;
    tick();
    check("t4_first_sel", 32'(sel), 32'h7);
    check("t4_first_gnt", 32'(gnt), 32'h80);
    check("t4_first_data", 32'(out_data), 32'h77);
    for (int b = 0; b < 4; b++) tick();
    check("t4_mid_rel", 32'(gnt), 32'h00);
    tick();
    check("t4_second_sel", 32'(sel), 32'h2);
    check("t4_second_gnt", 32'(gnt), 32'h04);

    // 5: withdraw requester 2 (ptr becomes 3), grant 5 and stall 10 cycles
    req = 8'h00;
    #1;
    check("t5_withdraw_valid", 32'(out_valid), 32'h0);
    tick();
    check("t5_withdraw_rel", 32'(busy), 32'h0);
    req = 8'h20;
    out_ready = 1'b0;
    tick();
    for (int c = 0; c < 10; c++) begin
      check("t5_stall_gnt", 32'(gnt), 32'h20);
      check("t5_stall_valid", 32'(out_valid), 32'h1);
      tick();
    end
    out_ready = 1'b1;
    for (int b = 0; b < 4; b++) begin
      check("t5_beat_gnt", 32'(gnt), 32'h20);
      tick();
    end
    check("t5_rel_gnt", 32'(gnt), 32'h00);

    // 6: requester 3 drops after two transfers
    req = 8'h08;
    tick();
    check("t6_sel3", 32'(sel), 32'h3);
    check("t6_data3", 32'(out_data), 32'h33);
    tick();
    tick();
    req = 8'h00;
    #1;
    check("t6_drop_valid", 32'(out_valid), 32'h0);
    check("t6_drop_gnt_held", 32'(gnt), 32'h08);
    tick();
    check("t6_drop_rel_gnt", 32'(gnt), 32'h00);
    check("t6_drop_rel_busy", 32'(busy), 32'h0);

    // Mid-burst reset of requester 6 (ptr=4 so 6 wins)
    req = 8'h40;
    tick();
    check("t6_sel6", 32'(sel), 32'h6);
    tick();
    #2;
    rst = 1'b1;
    #1;
    check("t6_arst_gnt", 32'(gnt), 32'h00);
    check("t6_arst_busy", 32'(busy), 32'h0);
    check("t6_arst_sel", 32'(sel), 32'h0);
    check("t6_arst_valid", 32'(out_valid), 32'h0);
    check("t6_arst_data", 32'(out_data), 32'hA5);
    tick();
    rst = 1'b0;
    // ptr back at 0: with 1 and 6 requesting, 1 must win
    req = 8'h42;
    tick();
    check("t6_ptr_reset_sel", 32'(sel), 32'h1);
    check("t6_ptr_reset_gnt", 32'(gnt), 32'h02);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
